// File: rtl/signed_compare_scheduler.sv
// Purpose: round-robin scheduler sharing one signed 32-bit comparator among NUM_REQ requesters.
// Latency: accept edge T -> EVAL in cycle T+1 -> response valid in cycle T+2; one compare per 3 cycles.
// Backpressure: response is held in RESP until the owner's resp_ready; no request is accepted meanwhile.
module signed_compare_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic                            resp_gt,
  output logic                            resp_eq,
  output logic                            resp_lt,
  output logic                            busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Pointer starts at the last requester so requester 0 wins the first round.
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  // Elaboration-time guards on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("signed_compare_scheduler: NUM_REQ must be in 2..4");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("signed_compare_scheduler: DATA_WIDTH must be 32");
  end

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [IDW-1:0]        cur_id_q, cur_id_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]            flags_q, flags_d;   // {gt, eq, lt}
  logic                  busy_q, busy_d;

  logic                  grant_vld;
  logic [IDW-1:0]        grant_id;
  logic                  accept;
  logic                  cmp_gt, cmp_eq, cmp_lt;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx[IDW-1:0];
      end
    end
  end

  // Ready is offered only in IDLE, and only to the winning requester.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept = (state_q == S_IDLE) && grant_vld;

  // The single shared comparator: signed less-than and equality, gt is the remainder.
  always_comb begin
    cmp_lt = $signed(op_a_q) < $signed(op_b_q);
    cmp_eq = (op_a_q == op_b_q);
    cmp_gt = !cmp_lt && !cmp_eq;
  end

  // Sequencer next-state: IDLE -> EVAL -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    flags_d      = flags_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d       = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
          op_b_d       = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
          cur_id_d     = grant_id;
          last_grant_d = grant_id;
          state_d      = S_EVAL;
        end
      end
      S_EVAL: begin
        flags_d = {cmp_gt, cmp_eq, cmp_lt};
        state_d = S_RESP;
      end
      S_RESP: begin
        // Only the owner's resp_ready can close the transaction.
        if (resp_ready[cur_id_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, operand, flag and busy registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_ID;
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      flags_q      <= 3'b000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      flags_q      <= flags_d;
      busy_q       <= busy_d;
    end
  end

  // One-hot response valid toward the owner of the current transaction.
  always_comb begin
    resp_valid = '0;
    if (state_q == S_RESP) begin
      resp_valid[cur_id_q] = 1'b1;
    end
  end

  assign resp_gt = flags_q[2];
  assign resp_eq = flags_q[1];
  assign resp_lt = flags_q[0];
  assign busy    = busy_q;

endmodule

// File: tb/tb_signed_compare_scheduler.sv
// Bench for signed_compare_scheduler with three requesters.
// Vector table for signed corners and latency, plus hand sequences for
// backpressure, withdrawn request, mid-RESP reset and round-robin fairness.
module tb_signed_compare_scheduler;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic            resp_gt, resp_eq, resp_lt, busy;

  signed_compare_scheduler #(.NUM_REQ(N), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_gt    (resp_gt),
    .resp_eq    (resp_eq),
    .resp_lt    (resp_lt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        gt;
    logic        eq;
    logic        lt;
  } vec_t;

  typedef struct {
    int   id;
    logic gt;
    logic eq;
    logic lt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [N-1:0] oh(int id);
    logic [N-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response handshake pops and checks one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && |(resp_valid & resp_ready)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=%b expected=none at %0t", resp_valid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp", {26'd0, resp_valid, resp_gt, resp_eq, resp_lt},
            {26'd0, oh(mon_e.id), mon_e.gt, mon_e.eq, mon_e.lt});
      end
    end
  end

  // One uncontended transaction with latency checks; starts and ends in IDLE.
  task automatic run_vec(vec_t v);
    @(posedge clk); #2;
    req_valid = oh(v.id);
    req_a[v.id*32 +: 32] = v.a;
    req_b[v.id*32 +: 32] = v.b;
    resp_ready = '1;
    @(negedge clk);
    chk("grant", {29'd0, req_ready}, {29'd0, oh(v.id)});
    exp_q.push_back('{v.id, v.gt, v.eq, v.lt});
    @(posedge clk); #2;               // accept edge T passed
    req_valid = '0;
    req_a = {$urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom};
    @(negedge clk);                   // cycle T+1: EVAL
    chk("eval_state", {28'd0, resp_valid, busy}, {28'd0, 3'b000, 1'b1});
    @(negedge clk);                   // cycle T+2: RESP
    chk("lat2", {29'd0, resp_valid}, {29'd0, oh(v.id)});
    @(posedge clk);
  endtask

  vec_t vecs[9];
  int   n;

  initial begin
    vecs[0] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{2, 32'h00000005, 32'h00000007, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    req_a      = '0;
    req_b      = '0;
    #1 rst_n = 1'b0;

    // Reset defaults and first grant.
    #11;
    chk("reset_outputs", {22'd0, req_ready, resp_valid, busy, resp_gt, resp_eq, resp_lt}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    req_valid = 3'b011;
    req_a[31:0] = 32'd3;  req_b[31:0] = 32'd9;
    req_a[63:32] = 32'd4; req_b[63:32] = 32'd4;
    @(negedge clk);
    chk("first_grant", {29'd0, req_ready}, 32'b001);
    exp_q.push_back('{0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);

    // Signed corners and latency.
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Response backpressure on requester 2; other resp_ready bits high.
    @(posedge clk); #2;
    req_valid = 3'b100;
    req_a[95:64] = 32'hFFFFFFFD;
    req_b[95:64] = 32'h00000002;
    resp_ready = 3'b011;
    @(negedge clk);
    chk("bp_grant", {29'd0, req_ready}, 32'b100);
    exp_q.push_back('{2, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #2;
    req_valid = 3'b011;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {22'd0, resp_valid, resp_gt, resp_eq, resp_lt, req_ready, busy},
          {22'd0, 3'b100, 3'b001, 3'b000, 1'b1});
    end
    @(posedge clk); #2;
    resp_ready = 3'b111;
    req_valid  = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", {28'd0, resp_valid, busy}, 32'd0);

    // Withdrawn request: requester 1 toggles while the engine is busy.
    @(posedge clk); #2;
    req_valid = 3'b001;
    req_a[31:0] = 32'd5; req_b[31:0] = 32'd5;
    resp_ready = 3'b110;
    @(negedge clk);
    chk("wd_grant", {29'd0, req_ready}, 32'b001);
    exp_q.push_back('{0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #2;
    req_valid = 3'b010;
    @(posedge clk); #2;
    req_valid = 3'b000;
    @(negedge clk);
    chk("wd_resp", {29'd0, resp_valid}, 32'b001);
    @(posedge clk); #2;
    resp_ready = 3'b111;
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wd_idle", {28'd0, resp_valid, busy}, 32'd0);
    end
    @(posedge clk); #2;
    req_valid = 3'b011;
    req_a[63:32] = 32'd1; req_b[63:32] = 32'd2;
    @(negedge clk);
    chk("wd_pointer", {29'd0, req_ready}, 32'b010);
    exp_q.push_back('{1, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);

    // Reset in the middle of RESP with requester 1 pending.
    @(posedge clk); #2;
    req_valid = 3'b001;
    req_a[31:0] = 32'd9; req_b[31:0] = 32'd1;
    resp_ready = 3'b110;
    @(negedge clk);
    chk("rst_grant0", {29'd0, req_ready}, 32'b001);
    exp_q.push_back('{0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #2;
    req_valid = 3'b010;
    req_a[63:32] = 32'hFFFFFFF0; req_b[63:32] = 32'hFFFFFFF0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_resp", {29'd0, resp_valid}, 32'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", {22'd0, req_ready, resp_valid, busy, resp_gt, resp_eq, resp_lt}, {22'd0, 3'b010, 7'd0});
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    resp_ready = 3'b111;
    @(negedge clk);
    chk("rst_grant1", {29'd0, req_ready}, 32'b010);
    exp_q.push_back('{1, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);

    // Fresh reset, then all three requesters contend for nine grants.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = i;
      req_b[i*32 +: 32] = 32'd1;
    end
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{i % 3, (i % 3) == 2, (i % 3) == 1, (i % 3) == 0});
    end
    resp_ready = 3'b111;
    req_valid  = 3'b111;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    req_valid = '0;
    chk("fair_done", exp_q.size(), 32'd0);

    repeat (4) @(posedge clk);
    #2;
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
